// File: rtl/csk_pkg.sv
// Shared types and defaults for the carry-skip adder.
// Combinational helpers only; no clocked state.
package csk_pkg;

  localparam int CSK_N_DEF   = 32;
  localparam int CSK_BLK_DEF = 4;

  typedef struct packed {
    logic p;
    logic g;
  } pg_t;

  function automatic int csk_nblk(input int n, input int blk);
    return n / blk;
  endfunction

endpackage

// File: rtl/csk_block.sv
// One carry-skip block: ripple inside, AND-OR skip around it (no select mux).
// Purely combinational, 0 cycles; no handshake.
module csk_block
  import csk_pkg::*;
#(
  parameter int BLK = CSK_BLK_DEF
) (
  input  logic [BLK-1:0] a,
  input  logic [BLK-1:0] b,
  input  logic           cin,
  output logic [BLK-1:0] s,
  output logic           cout,
  output logic           pblk
);

  pg_t  [BLK-1:0] w_pg;
  logic [BLK:0]   w_c;

  always_comb begin
    w_pg   = '0;
    w_c    = '0;
    s      = '0;
    pblk   = 1'b1;
    w_c[0] = cin;
    for (int i = 0; i < BLK; i++) begin
      w_pg[i].p = a[i] ^ b[i];
      w_pg[i].g = a[i] & b[i];
      s[i]      = w_pg[i].p ^ w_c[i];
      w_c[i+1]  = w_pg[i].g | (w_pg[i].p & w_c[i]);
      pblk      = pblk & w_pg[i].p;
    end
    // Skip term ORed onto the ripple carry: the skip only ever forwards cin.
    cout = w_c[BLK] | (pblk & cin);
  end

endmodule

// File: rtl/csk_sin_mux.sv
// N-bit carry-skip adder {Cout,S} = A+B+Cin; CSK_OVF_EN adds a registered signed-overflow flag.
// Latency 1 cycle, accepts a new operation every clock; no backpressure.
module csk_sin_mux
  import csk_pkg::*;
#(
  parameter int N   = CSK_N_DEF,
  parameter int BLK = CSK_BLK_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Cin,
  output logic [N-1:0] S,
  output logic         Cout
`ifdef CSK_OVF_EN
  ,
  output logic         OVF
`endif
);

  localparam int NBLK = csk_nblk(N, BLK);

  if (N % BLK != 0) begin : g_bad_cfg
    $error("csk_sin_mux: N must be a multiple of BLK");
  end

  logic [N-1:0] w_sum;
  logic         w_cout;
  logic [N-1:0] r_s;
  logic         r_cout;

  for (genvar j = 0; j < NBLK; j++) begin : g_blk
    logic w_ci;
    logic w_co;
    logic w_pblk;

    if (j == 0) begin : g_first
      assign w_ci = Cin;
    end else begin : g_next
      assign w_ci = g_blk[j-1].w_co;
    end

    csk_block #(.BLK(BLK)) u_blk (
      .a    (A[j*BLK +: BLK]),
      .b    (B[j*BLK +: BLK]),
      .cin  (w_ci),
      .s    (w_sum[j*BLK +: BLK]),
      .cout (w_co),
      .pblk (w_pblk)
    );

    // An all-propagate block must hand its carry-in straight through.
    always_comb begin
      if (w_pblk) assert (w_co == w_ci);
    end
  end

  assign w_cout = g_blk[NBLK-1].w_co;

`ifdef CSK_OVF_EN
  logic w_c_msb;
  logic r_ovf;
  // Carry into the MSB recovered from its sum bit, avoiding an extra block port.
  assign w_c_msb = w_sum[N-1] ^ A[N-1] ^ B[N-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_ovf <= 1'b0;
    else        r_ovf <= w_cout ^ w_c_msb;
  end

  assign OVF = r_ovf;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s    <= '0;
      r_cout <= 1'b0;
    end else begin
      r_s    <= w_sum;
      r_cout <= w_cout;
    end
  end

  assign S    = r_s;
  assign Cout = r_cout;

endmodule

// File: tb/tb_csk_sin_mux.sv
// Scoreboard bench for csk_sin_mux (N=32, BLK=4); define CSK_OVF_EN to also check OVF.
module tb_csk_sin_mux;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] A, B, S;
  logic        Cin, Cout;
`ifdef CSK_OVF_EN
  logic        OVF;
`endif

  always #5 clk = ~clk;

  csk_sin_mux #(.N(32), .BLK(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .A     (A),
    .B     (B),
    .Cin   (Cin),
    .S     (S),
    .Cout  (Cout)
`ifdef CSK_OVF_EN
    ,
    .OVF   (OVF)
`endif
  );

  typedef struct {
    logic [31:0] s;
    logic        c;
    logic        o;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  logic tb_vld   = 1'b0;

  function automatic logic ovf_of(input logic [31:0] a, input logic [31:0] b, input logic [31:0] s);
    return (a[31] == b[31]) && (s[31] != a[31]);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic ci,
                       input logic [31:0] es, input logic ec);
    exp_t e;
    @(negedge clk);
    A = a; B = b; Cin = ci; tb_vld = 1'b1;
    e.s = es; e.c = ec; e.o = ovf_of(a, b, es);
    sb.push_back(e);
  endtask

  task automatic check_cleared(input string name);
    check({name, "_S"}, S, 32'h0);
    check({name, "_Cout"}, {31'b0, Cout}, 32'h0);
`ifdef CSK_OVF_EN
    check({name, "_OVF"}, {31'b0, OVF}, 32'h0);
`endif
  endtask

  // Monitor: each posedge that captured a valid operation yields one result.
  initial begin
    exp_t e;
    logic v;
    forever begin
      @(posedge clk);
      v = tb_vld && rst_n;
      #1;
      if (v) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL sb_underflow actual=S:%h required=no_output", S);
        end else begin
          e = sb.pop_front();
          check("sum", S, e.s);
          check("cout", {31'b0, Cout}, {31'b0, e.c});
`ifdef CSK_OVF_EN
          check("ovf", {31'b0, OVF}, {31'b0, e.o});
`endif
        end
      end
    end
  end

  initial begin
    logic [32:0] sum33;
    logic [31:0] ra, rb;
    logic        rc;

    rst_n = 1'b0; A = '0; B = '0; Cin = 1'b0;
    repeat (2) @(negedge clk);
    check_cleared("reset");
    rst_n = 1'b1;

    issue(32'd3,          32'hFFFF_FFFE, 1'b0, 32'h0000_0001, 1'b1);
    issue(32'hFFFF_FFFF,  32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1);
    issue(32'h5555_AAAA,  32'hAAAA_5555, 1'b1, 32'h0000_0000, 1'b1);
    issue(32'h1234_5678,  32'h0000_0000, 1'b0, 32'h1234_5678, 1'b0);
    issue(32'd1,          32'd1,         1'b0, 32'd2,         1'b0);
    issue(32'd7,          32'd8,         1'b0, 32'd15,        1'b0);
    issue(32'hFFFF_FFFF,  32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1);
    issue(32'hDEAD_BEEF,  32'h2152_4110, 1'b1, 32'h0000_0000, 1'b1);
    issue(32'hFFFF_FFFF,  32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1);
    issue(32'h7FFF_FFFF,  32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0);
    issue(32'h8000_0000,  32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1);
    issue(32'h0000_0000,  32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0);
    issue(32'h0000_0100,  32'h0000_0200, 1'b0, 32'h0000_0300, 1'b0);

    // Reset between edges with a nonzero result on the outputs and a new op pending.
    @(negedge clk);
    tb_vld = 1'b0; A = 32'hFFFF_FFFF; B = 32'h0000_0001; Cin = 1'b1;
    #2 rst_n = 1'b0;
    #1 check_cleared("midrst");
    @(posedge clk);
    #1 check_cleared("midrst_hold");
    @(negedge clk);
    rst_n = 1'b1;
    #1 check_cleared("midrst_release");

    for (int i = 0; i < 2000; i++) begin
      ra = $urandom;
      rb = $urandom;
      rc = 1'($urandom_range(1, 0));
      sum33 = {1'b0, ra} + {1'b0, rb} + {32'b0, rc};
      issue(ra, rb, rc, sum33[31:0], sum33[32]);
    end

    @(negedge clk);
    tb_vld = 1'b0;
    for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
    n_checks++;
    if (sb.size() != 0) begin
      n_errors++;
      $display("FAIL drain actual=%0d_pending required=0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
